mod_inverse_checker: RTL and testbench
======================================

// Module: mod_inverse_checker
// PURPOSE
// - Consumer end of the modular-inverse datapath: takes (prime, a, a_inverse) from the inverse unit.
// - Computes a*a_inverse mod prime by bit-serial interleaved modular multiplication.
// - Reports the product and ok = (product == 1).
// - Sits between the inverse unit and downstream crypto logic; valid/ready on both sides.
// PARAMETERS
// - W  8  operand width in bits; prime, a, a_inverse and the product are all W bits.
// PORTS
// - clk        in   1  rising-edge clock; single clock domain
// - rst_n      in   1  asynchronous active-low reset
// - in_valid   in   1  input triple valid
// - in_ready   out  1  block can accept a triple
// - prime      in   W  modulus; must be >= 2
// - a          in   W  operand; must be < prime
// - a_inverse  in   W  candidate inverse; must be < prime
// - out_valid  out  1  result valid; held until taken
// - out_ready  in   1  downstream accepts the result
// - product    out  W  a*a_inverse mod prime (0 when range_err=1)
// - ok         out  1  1 when product==1 and range_err==0
// - range_err  out  1  input out of range: prime<2, a>=prime or a_inverse>=prime
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; product=0; ok=0; range_err=0.
// - FSM states and transitions:
//   - IDLE: in_ready=1. On in_valid&in_ready, latch the triple.
//     - Range check fails: go to DONE with range_err=1, product=0, ok=0.
//     - Otherwise: acc=0, bit index i=W-1, go to MUL.
//   - MUL: in_ready=0. Once per cycle:
//     - acc = 2*acc mod p; then if b[i], acc = acc + a mod p.
//     - Each reduction is one conditional subtract on a W+1-bit intermediate.
//     - At i==0 go to DONE; otherwise decrement i.
//   - DONE: out_valid=1; product=acc; ok=(acc==1). When out_ready=1, go to IDLE.
// - Latency from the accept edge:
//   - Valid triple: out_valid rises after exactly W+1 clocks.
//   - Range error: out_valid rises after 1 clock.
// - Throughput: one triple per W+2 cycles at best; no new accept while in MUL or DONE.
// - product, ok and range_err are stable for as long as out_valid=1.
// - Inputs are sampled only on the accept edge; later changes on the input ports are ignored.
// - out_ready while out_valid=0 has no effect.
// - In_valid arriving in the same cycle as DONE->IDLE is not accepted until the next cycle (in_ready is registered).
// - rst_n asserted mid-MUL or in DONE: abort immediately to reset values; the in-flight result is discarded.
// - Arithmetic: all intermediates are W+1 bits; acc < prime is an invariant after every step.
// CONFIGURATION
// - Macro INVCHK_ERRCNT_EN defined:
//   - Adds output err_count [15:0].
//   - Increments on each DONE->IDLE handshake with ok=0; saturates at 16'hFFFF.
//   - Reset value 0.
// - Macro undefined: the port and the counter do not exist; all other behaviour is identical.
// STRUCTURE
// - invchk_pkg holds: FSM state enum (IDLE/MUL/DONE), default W, and the index width localparam $clog2(W).
// - Sub-module mod_dbl_add_step: combinational (acc, a, p, bit) -> next acc.
//   - Two conditional subtracts.
//   - Instantiated once in MUL.
// TESTING
// - p=5, a=3, a_inverse=2 -> product=1, ok=1, range_err=0; out_valid exactly 9 clocks after accept (W=8).
// - p=13, a=11, a_inverse=6 -> product=1, ok=1.
// - p=13, a=11, a_inverse=6, then p=13, a=11, a_inverse=5 -> product=3, ok=0; err_count=1 when INVCHK_ERRCNT_EN.
// - p=251, a=250, a_inverse=250 -> product=1, ok=1 (checks the wide intermediate).
// - p=7, a=9, a_inverse=1 -> range_err=1, product=0, ok=0, 1-clock latency.
// - p=1 -> range_err=1, product=0, ok=0, 1-clock latency.
// - Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0.
// - Pull rst_n low at MUL step 4 -> all outputs at reset values; the next triple processes correctly.

Source files
------------

// File: rtl/invchk_pkg.sv
// Shared types and constants for the modular-inverse checker.
// The FSM state enum, the default operand width and the bit-index width.
package invchk_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_W = 8;
   localparam int IDX_W     = $clog2(DEFAULT_W);

endpackage

// File: rtl/mod_dbl_add_step.sv
// One step of interleaved modular multiplication: acc_next = (2*acc + bit*a) mod p.
// Requires acc < p and a < p, so each reduction needs only one conditional subtract.
module mod_dbl_add_step #(
   parameter int W = 8
) (
   input  logic [W-1:0] acc,
   input  logic [W-1:0] a,
   input  logic [W-1:0] p,
   input  logic         add_bit,
   output logic [W-1:0] acc_next
);

   logic [W:0] p_ext;
   logic [W:0] dbl;
   logic [W:0] dbl_red;
   logic [W:0] sum;

   // All intermediates carry one extra bit so 2*acc and dbl+a never overflow.
   always_comb begin
      p_ext   = {1'b0, p};
      dbl     = {acc, 1'b0};
      dbl_red = (dbl >= p_ext) ? (dbl - p_ext) : dbl;
      sum     = dbl_red + {1'b0, a};
      if (add_bit) begin
         acc_next = (sum >= p_ext) ? W'(sum - p_ext) : W'(sum);
      end else begin
         acc_next = W'(dbl_red);
      end
   end

endmodule

// File: rtl/mod_inverse_checker.sv
// Checks a candidate modular inverse by computing a*a_inverse mod prime bit-serially.
// Optional feature: define INVCHK_ERRCNT_EN to add a saturating err_count output.
module mod_inverse_checker
   import invchk_pkg::*;
#(
   parameter int W = DEFAULT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] prime,
   input  logic [W-1:0] a,
   input  logic [W-1:0] a_inverse,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] product,
   output logic         ok,
   output logic         range_err
`ifdef INVCHK_ERRCNT_EN
   ,
   output logic [15:0]  err_count
`endif
);

   localparam int IW = (W > 1) ? $clog2(W) : 1;

   state_t         state;
   state_t         state_next;
   logic [W-1:0]   p_r;
   logic [W-1:0]   a_r;
   logic [W-1:0]   b_r;
   logic [W-1:0]   acc;
   logic [W-1:0]   acc_next;
   logic [IW-1:0]  idx;
   logic [W-1:0]   product_r;
   logic           ok_r;
   logic           range_err_r;
   logic           in_range;
   logic           accept;
   logic           take;

   assign in_range  = (prime >= W'(2)) && (a < prime) && (a_inverse < prime);
   assign accept    = in_valid && (state == IDLE);
   assign take      = out_ready && (state == DONE);
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign product   = product_r;
   assign ok        = ok_r;
   assign range_err = range_err_r;

   mod_dbl_add_step #(.W(W)) u_step (
      .acc      (acc),
      .a        (a_r),
      .p        (p_r),
      .add_bit  (b_r[idx]),
      .acc_next (acc_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = in_range ? MUL : DONE;
         MUL:  if (idx == '0) state_next = DONE;
         DONE: if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operands are captured only on the accept edge; the MSB of a_inverse is consumed first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_r         <= '0;
         a_r         <= '0;
         b_r         <= '0;
         acc         <= '0;
         idx         <= '0;
         product_r   <= '0;
         ok_r        <= 1'b0;
         range_err_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  p_r <= prime;
                  a_r <= a;
                  b_r <= a_inverse;
                  acc <= '0;
                  idx <= IW'(W - 1);
                  if (!in_range) begin
                     product_r   <= '0;
                     ok_r        <= 1'b0;
                     range_err_r <= 1'b1;
                  end
               end
            end
            MUL: begin
               acc <= acc_next;
               if (idx == '0) begin
                  product_r   <= acc_next;
                  ok_r        <= (acc_next == W'(1));
                  range_err_r <= 1'b0;
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef INVCHK_ERRCNT_EN
   // Counts results handed downstream that did not verify, saturating at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= '0;
      end else if (take && !ok_r && (err_count != 16'hFFFF)) begin
         err_count <= err_count + 16'd1;
      end
   end
`else
   logic unused_take;
   assign unused_take = take;
`endif

endmodule

// File: tb/tb_mod_inverse_checker.sv
// Directed self-checking bench for mod_inverse_checker with a result scoreboard.
// Honours INVCHK_ERRCNT_EN to also check err_count.
module tb_mod_inverse_checker;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] prime;
   logic [W-1:0] a;
   logic [W-1:0] a_inverse;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] product;
   logic         ok;
   logic         range_err;
`ifdef INVCHK_ERRCNT_EN
   logic [15:0]  err_count;
   int           exp_err_count;
`endif

   typedef struct {
      logic [W-1:0] product;
      logic         ok;
      logic         range_err;
      int           latency;
   } exp_t;

   exp_t sb[$];
   int   n_checks;
   int   n_pass;

   mod_inverse_checker #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .prime     (prime),
      .a         (a),
      .a_inverse (a_inverse),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .ok        (ok),
      .range_err (range_err)
`ifdef INVCHK_ERRCNT_EN
      ,
      .err_count (err_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int observed, input int expected);
      n_checks++;
      assert (observed === expected) n_pass++;
      else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one triple and queues its expected result using plain integer arithmetic.
   task automatic applyStimulus(input int p, input int x, input int y);
      exp_t e;
      int   waited;
      waited = 0;
      while (!in_ready && waited < 50) begin
         tick();
         waited++;
      end
      check("in_ready_wait", int'(in_ready), 1);
      if (p < 2 || x >= p || y >= p) begin
         e.product = '0; e.ok = 1'b0; e.range_err = 1'b1; e.latency = 1;
      end else begin
         e.product   = W'((x * y) % p);
         e.ok        = (((x * y) % p) == 1);
         e.range_err = 1'b0;
         e.latency   = W + 1;
      end
      sb.push_back(e);
      prime     = W'(p);
      a         = W'(x);
      a_inverse = W'(y);
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
      prime     = W'($urandom);
      a         = W'($urandom);
      a_inverse = W'($urandom);
   endtask

   task automatic checkOutput(input string tag, input int hold_cycles);
      exp_t e;
      int   lat;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 1, 0);
         return;
      end
      e   = sb.pop_front();
      lat = 1;
      while (!out_valid && lat < 50) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, lat, e.latency);
      for (int h = 0; h <= hold_cycles; h++) begin
         check({tag, "_product"}, int'(product), int'(e.product));
         check({tag, "_ok"}, int'(ok), int'(e.ok));
         check({tag, "_range_err"}, int'(range_err), int'(e.range_err));
         if (hold_cycles > 0) begin
            check({tag, "_hold_valid"}, int'(out_valid), 1);
            check({tag, "_hold_in_ready"}, int'(in_ready), 0);
         end
         if (h < hold_cycles) tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
`ifdef INVCHK_ERRCNT_EN
      if (!e.ok) exp_err_count++;
      check({tag, "_err_count"}, int'(err_count), exp_err_count);
`endif
      check({tag, "_idle_out_valid"}, int'(out_valid), 0);
      check({tag, "_idle_in_ready"}, int'(in_ready), 1);
   endtask

   task automatic checkResetValues(input string tag);
      check({tag, "_in_ready"}, int'(in_ready), 1);
      check({tag, "_out_valid"}, int'(out_valid), 0);
      check({tag, "_product"}, int'(product), 0);
      check({tag, "_ok"}, int'(ok), 0);
      check({tag, "_range_err"}, int'(range_err), 0);
`ifdef INVCHK_ERRCNT_EN
      check({tag, "_err_count"}, int'(err_count), 0);
`endif
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      prime     = '0;
      a         = '0;
      a_inverse = '0;
`ifdef INVCHK_ERRCNT_EN
      exp_err_count = 0;
`endif
      tick();
      tick();
      checkResetValues("reset");
      rst_n = 1'b1;
      tick();

      applyStimulus(5, 3, 2);
      checkOutput("p5", 0);
      applyStimulus(13, 11, 6);
      checkOutput("p13_ok", 0);
      applyStimulus(13, 11, 5);
      checkOutput("p13_bad", 0);
      applyStimulus(251, 250, 250);
      checkOutput("p251", 0);
      applyStimulus(7, 9, 1);
      checkOutput("range_a", 0);
      applyStimulus(1, 0, 0);
      checkOutput("range_p1", 0);
      applyStimulus(11, 3, 4);
      checkOutput("hold", 5);

      // Abort mid-multiply; the in-flight result is dropped from the scoreboard.
      applyStimulus(13, 11, 6);
      for (int k = 0; k < 4; k++) tick();
      out_ready = 1'b1;
      rst_n = 1'b0;
      #1;
      checkResetValues("mid_reset");
      void'(sb.pop_front());
      out_ready = 1'b0;
      tick();
      rst_n = 1'b1;
`ifdef INVCHK_ERRCNT_EN
      exp_err_count = 0;
`endif
      tick();
      applyStimulus(17, 5, 7);
      checkOutput("after_reset", 0);
      applyStimulus(17, 5, 3);
      checkOutput("after_reset_bad", 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
